// File: rtl/pix_gray_conv.sv
// Colour-to-gray/binary pixel converter with frame-synchronised configuration,
// a fixed 3-stage datapath and an input-side stream protocol checker.
module pix_gray_conv #(
    parameter int R_W   = 5,
    parameter int G_W   = 6,
    parameter int B_W   = 5,
    parameter int OUT_W = 8,
    parameter int CNT_W = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [R_W+G_W+B_W-1:0]   din,
    input  logic                     din_vld,
    input  logic                     din_sop,
    input  logic                     din_eop,
    input  logic [1:0]               cfg_mode,
    input  logic [7:0]               cfg_kr,
    input  logic [7:0]               cfg_kg,
    input  logic [7:0]               cfg_kb,
    input  logic [OUT_W-1:0]         cfg_thr,
    input  logic                     err_clr,
    output logic [OUT_W-1:0]         dout,
    output logic                     dout_vld,
    output logic                     dout_sop,
    output logic                     dout_eop,
    output logic [CNT_W-1:0]         frame_pix,
    output logic                     err_sop,
    output logic                     err_eop
);

    localparam int PIX_W  = R_W + G_W + B_W;
    localparam int PROD_W = OUT_W + 8;
    localparam int WSUM_W = OUT_W + 10;
    localparam int CSUM_W = OUT_W + 2;
    localparam int AVG_W  = CSUM_W + 7;

    localparam logic [OUT_W-1:0] THR_RST = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_WEIGHT = 2'd0,
        MODE_AVG    = 2'd1,
        MODE_THR    = 2'd2,
        MODE_GREEN  = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e            mode;
        logic [7:0]       kr;
        logic [7:0]       kg;
        logic [7:0]       kb;
        logic [OUT_W-1:0] thr;
    } cfg_t;

    localparam cfg_t CFG_RST = '{mode: MODE_WEIGHT, kr: 8'd77, kg: 8'd150,
                                 kb: 8'd29, thr: THR_RST};

    // ---------------- channel split and MSB-replication expansion
    logic [R_W-1:0]   r_in;
    logic [G_W-1:0]   g_in;
    logic [B_W-1:0]   b_in;
    logic [OUT_W-1:0] r_exp, g_exp, b_exp;

    assign r_in = din[PIX_W-1 -: R_W];
    assign g_in = din[G_W+B_W-1 -: G_W];
    assign b_in = din[B_W-1:0];

    generate
        if (R_W == OUT_W) begin : g_r_full
            assign r_exp = r_in;
        end else begin : g_r_rep
            assign r_exp = {r_in, r_in[R_W-1 -: OUT_W-R_W]};
        end
        if (G_W == OUT_W) begin : g_g_full
            assign g_exp = g_in;
        end else begin : g_g_rep
            assign g_exp = {g_in, g_in[G_W-1 -: OUT_W-G_W]};
        end
        if (B_W == OUT_W) begin : g_b_full
            assign b_exp = b_in;
        end else begin : g_b_rep
            assign b_exp = {b_in, b_in[B_W-1 -: OUT_W-B_W]};
        end
    endgenerate

    // ---------------- configuration shadow
    logic sop_in, eop_in;
    cfg_t cfg_in, shadow, cfg_px;

    assign sop_in = din_vld & din_sop;
    assign eop_in = din_vld & din_eop;
    assign cfg_in = '{mode: mode_e'(cfg_mode), kr: cfg_kr, kg: cfg_kg,
                      kb: cfg_kb, thr: cfg_thr};
    // A frame's first pixel already uses the configuration it loads.
    assign cfg_px = sop_in ? cfg_in : shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= CFG_RST;
        end else if (sop_in) begin
            shadow <= cfg_in;
        end
    end

    // ---------------- pipeline control (reset)
    logic v1, sop1, eop1, v2, sop2, eop2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            sop1 <= 1'b0;
            eop1 <= 1'b0;
            v2   <= 1'b0;
            sop2 <= 1'b0;
            eop2 <= 1'b0;
        end else begin
            v1   <= din_vld;
            sop1 <= sop_in;
            eop1 <= eop_in;
            v2   <= v1;
            sop2 <= sop1;
            eop2 <= eop1;
        end
    end

    // ---------------- pipeline datapath (S1, S2)
    logic [OUT_W-1:0]  re1, ge1, be1, ge2;
    cfg_t              cfg1;
    logic [PROD_W-1:0] pr2, pg2, pb2;
    logic [CSUM_W-1:0] csum2;
    mode_e             mode2;
    logic [OUT_W-1:0]  thr2;

    // NOTE: datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        re1   <= r_exp;
        ge1   <= g_exp;
        be1   <= b_exp;
        cfg1  <= cfg_px;
        pr2   <= PROD_W'(re1) * PROD_W'(cfg1.kr);
        pg2   <= PROD_W'(ge1) * PROD_W'(cfg1.kg);
        pb2   <= PROD_W'(be1) * PROD_W'(cfg1.kb);
        csum2 <= CSUM_W'(re1) + CSUM_W'(ge1) + CSUM_W'(be1);
        ge2   <= ge1;
        mode2 <= cfg1.mode;
        thr2  <= cfg1.thr;
    end

    // ---------------- S3 result
    logic [WSUM_W-1:0] wsum, wshift;
    logic [AVG_W-1:0]  avg_full, avg_shift;
    logic [OUT_W-1:0]  w_sat, avg_val, result;

    assign wsum      = WSUM_W'(pr2) + WSUM_W'(pg2) + WSUM_W'(pb2);
    assign wshift    = wsum >> 8;
    assign w_sat     = (|wshift[WSUM_W-1:OUT_W]) ? '1 : wshift[OUT_W-1:0];
    assign avg_full  = AVG_W'(csum2) * AVG_W'(85);
    assign avg_shift = avg_full >> 8;
    // Cannot exceed OUT_W bits for 3 channels * 85/256; clamp keeps it explicit.
    assign avg_val   = (|avg_shift[AVG_W-1:OUT_W]) ? '1 : avg_shift[OUT_W-1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        result = w_sat;
        unique case (mode2)
            MODE_WEIGHT: result = w_sat;
            MODE_AVG:    result = avg_val;
            MODE_THR:    result = (w_sat >= thr2) ? '1 : '0;
            MODE_GREEN:  result = ge2;
            default:     result = w_sat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            dout_vld <= v2;
            dout_sop <= sop2;
            dout_eop <= eop2;
            if (v2) begin
                dout <= result;
            end
        end
    end

    // ---------------- protocol checker and frame counter
    logic             in_frame;
    logic [CNT_W-1:0] cnt, cnt_inc;

    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_frame  <= 1'b0;
            cnt       <= '0;
            frame_pix <= '0;
            err_sop   <= 1'b0;
            err_eop   <= 1'b0;
        end else begin
            if (sop_in) begin
                cnt      <= CNT_W'(1);
                in_frame <= ~din_eop;
                if (din_eop) begin
                    frame_pix <= CNT_W'(1);
                end
            end else if (din_vld && in_frame) begin
                cnt <= cnt_inc;
                if (din_eop) begin
                    frame_pix <= cnt_inc;
                    in_frame  <= 1'b0;
                end
            end
            err_sop <= err_clr ? 1'b0 : (err_sop | (sop_in & in_frame));
            err_eop <= err_clr ? 1'b0 : (err_eop | (eop_in & ~din_sop & ~in_frame));
        end
    end

endmodule

// File: tb/tb_pix_gray_conv.sv
// Self-checking bench for pix_gray_conv: per-cycle comparison against a
// behavioural model plus hand-computed literal expectations.
module tb_pix_gray_conv;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int OUT_W = 8;
    localparam int CNT_W = 24;
    localparam int PIX_W = R_W + G_W + B_W;
    localparam int LAT   = 3;
    localparam int OMAX  = (1 << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PIX_W-1:0] din = '0;
    logic             din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic [1:0]       cfg_mode = 2'd0;
    logic [7:0]       cfg_kr = 8'd77, cfg_kg = 8'd150, cfg_kb = 8'd29;
    logic [OUT_W-1:0] cfg_thr = 8'd128;
    logic             err_clr = 1'b0;
    logic [OUT_W-1:0] dout;
    logic             dout_vld, dout_sop, dout_eop;
    logic [CNT_W-1:0] frame_pix;
    logic             err_sop, err_eop;

    pix_gray_conv #(.R_W(R_W), .G_W(G_W), .B_W(B_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
        .din_eop(din_eop), .cfg_mode(cfg_mode), .cfg_kr(cfg_kr), .cfg_kg(cfg_kg),
        .cfg_kb(cfg_kb), .cfg_thr(cfg_thr), .err_clr(err_clr), .dout(dout),
        .dout_vld(dout_vld), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .frame_pix(frame_pix), .err_sop(err_sop), .err_eop(err_eop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model
    function automatic int expand(int c, int w);
        return (c << (OUT_W - w)) | (c >> (2 * w - OUT_W));
    endfunction

    function automatic int convert(int pix, int mode, int kr, int kg, int kb, int thr);
        int re, ge, be, w;
        re = expand((pix >> (G_W + B_W)) & ((1 << R_W) - 1), R_W);
        ge = expand((pix >> B_W) & ((1 << G_W) - 1), G_W);
        be = expand(pix & ((1 << B_W) - 1), B_W);
        w  = (re * kr + ge * kg + be * kb) / 256;
        if (w > OMAX) w = OMAX;
        case (mode)
            0: return w;
            1: return ((re + ge + be) * 85) / 256;
            2: return (w >= thr) ? OMAX : 0;
            default: return ge;
        endcase
    endfunction

    typedef struct {
        bit v;
        bit s;
        bit e;
        int val;
    } px_t;

    px_t hist[$];
    int  m_dout = 0, m_frame_pix = 0, m_cnt = 0;
    bit  m_vld = 0, m_sop = 0, m_eop = 0, m_in_frame = 0, m_err_sop = 0, m_err_eop = 0;
    int  sh_mode = 0, sh_kr = 77, sh_kg = 150, sh_kb = 29, sh_thr = 1 << (OUT_W - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            m_dout = 0; m_vld = 0; m_sop = 0; m_eop = 0;
            m_frame_pix = 0; m_cnt = 0; m_in_frame = 0; m_err_sop = 0; m_err_eop = 0;
            sh_mode = 0; sh_kr = 77; sh_kg = 150; sh_kb = 29; sh_thr = 1 << (OUT_W - 1);
        end else begin
            px_t p, o;
            bit sop_ok, eop_ok;
            sop_ok = din_vld && din_sop;
            eop_ok = din_vld && din_eop;
            if (sop_ok) begin
                sh_mode = cfg_mode; sh_kr = cfg_kr; sh_kg = cfg_kg; sh_kb = cfg_kb; sh_thr = cfg_thr;
            end
            p.v = din_vld; p.s = sop_ok; p.e = eop_ok;
            p.val = convert(din, sh_mode, sh_kr, sh_kg, sh_kb, sh_thr);
            hist.push_back(p);
            if (hist.size() == LAT) begin
                o = hist.pop_front();
                m_vld = o.v; m_sop = o.s; m_eop = o.e;
                if (o.v) m_dout = o.val;
            end
            if (err_clr) m_err_sop = 0; else if (sop_ok && m_in_frame) m_err_sop = 1;
            if (err_clr) m_err_eop = 0; else if (eop_ok && !din_sop && !m_in_frame) m_err_eop = 1;
            if (sop_ok) begin
                m_cnt = 1;
                m_in_frame = !din_eop;
                if (din_eop) m_frame_pix = 1;
            end else if (din_vld && m_in_frame) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (din_eop) begin
                    m_frame_pix = m_cnt;
                    m_in_frame = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare and output log
    int out_log[$];

    always @(negedge clk) begin
        check("dout", dout, m_dout);
        check("dout_vld", dout_vld, m_vld);
        check("dout_sop", dout_sop, m_sop);
        check("dout_eop", dout_eop, m_eop);
        check("frame_pix", frame_pix, m_frame_pix);
        check("err_sop", err_sop, m_err_sop);
        check("err_eop", err_eop, m_err_eop);
        if (dout_vld) out_log.push_back(int'(dout));
    end

    // ---------------- stimulus helpers
    task automatic px(input logic [PIX_W-1:0] d, input logic s, input logic e);
        din = d; din_vld = 1'b1; din_sop = s; din_eop = e;
        @(posedge clk); #1;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_cfg(input int mode, input int kr, input int kg, input int kb, input int thr);
        cfg_mode = 2'(mode); cfg_kr = 8'(kr); cfg_kg = 8'(kg); cfg_kb = 8'(kb); cfg_thr = OUT_W'(thr);
    endtask

    int lit_exp[13] = '{255, 76, 149, 28, 0, 254, 255, 0, 255, 255, 0, 0, 255};

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_dout", dout, 0);
        check("rst_frame_pix", frame_pix, 0);
        check("rst_dout_vld", dout_vld, 0);

        // Defaults, mode 0, back-to-back frame with latency probes
        set_cfg(0, 77, 150, 29, 128);
        px(16'hFFFF, 1, 0);
        check("lat_c1_vld", dout_vld, 0);
        px(16'hF800, 0, 0);
        check("lat_c2_vld", dout_vld, 0);
        px(16'h07E0, 0, 0);
        check("lat_c3_vld", dout_vld, 1);
        check("lat_c3_dout", dout, 255);
        check("lat_c3_sop", dout_sop, 1);
        px(16'h001F, 0, 0);
        px(16'h0000, 0, 1);
        idle(2);
        check("last_eop", dout_eop, 1);
        idle(2);
        check("frame_pix_5", frame_pix, 5);

        // Average and green pass-through, single-pixel frames
        set_cfg(1, 77, 150, 29, 128);
        px(16'hFFFF, 1, 1);
        idle(4);
        check("frame_pix_1", frame_pix, 1);
        set_cfg(3, 77, 150, 29, 128);
        px(16'h07E0, 1, 1);
        idle(4);

        // Threshold, mid-frame cfg change ignored until next sop
        set_cfg(2, 77, 150, 29, 128);
        px(16'hF800, 1, 0);
        px(16'h07E0, 0, 0);
        cfg_thr = 8'd200;
        px(16'h07E0, 0, 0);
        px(16'hF800, 0, 1);
        px(16'h07E0, 1, 1);
        idle(4);

        // Saturation of weighted sum
        set_cfg(0, 255, 255, 255, 128);
        px(16'hFFFF, 1, 1);
        idle(4);

        for (int i = 0; i < 13; i++) begin
            check($sformatf("lit_dout_%0d", i), (out_log.size() > i) ? out_log[i] : -1, lit_exp[i]);
        end

        // Protocol errors: restart without eop, stray eop, clear
        set_cfg(0, 77, 150, 29, 128);
        px(16'h1234, 1, 0);
        px(16'h0000, 0, 0);
        px(16'h0000, 0, 0);
        px(16'h5678, 1, 0);
        px(16'h0000, 0, 0);
        px(16'hFFFF, 0, 1);
        idle(4);
        check("err_sop_set", err_sop, 1);
        check("err_eop_clean", err_eop, 0);
        check("frame_pix_restart", frame_pix, 3);
        px(16'h0000, 0, 1);
        idle(2);
        check("err_eop_set", err_eop, 1);
        check("frame_pix_held", frame_pix, 3);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("err_sop_clr", err_sop, 0);
        check("err_eop_clr", err_eop, 0);

        // Gaps inside a frame
        px(16'h1111, 1, 0);
        idle(2);
        px(16'h2222, 0, 0);
        idle(3);
        px(16'h3333, 0, 0);
        idle(1);
        px(16'h4444, 0, 1);
        idle(4);
        check("frame_pix_gaps", frame_pix, 4);

        // Pixel outside a frame: converted with shadow cfg, not counted
        px(16'hF800, 0, 0);
        idle(2);
        check("outside_vld", dout_vld, 1);
        check("outside_dout", dout, 76);
        idle(2);
        check("outside_no_count", frame_pix, 4);

        // Reset mid-frame with pixels in flight
        set_cfg(1, 77, 150, 29, 128);
        px(16'hFFFF, 1, 0);
        px(16'hF800, 0, 0);
        rst_n = 1'b0;
        #2;
        check("midrst_dout", dout, 0);
        check("midrst_vld", dout_vld, 0);
        check("midrst_frame_pix", frame_pix, 0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("postrst_no_vld", dout_vld, 0);
        px(16'h07E0, 0, 1);
        idle(1);
        check("postrst_need_sop", err_eop, 1);
        px(16'h07E0, 1, 0);
        px(16'h07E0, 0, 1);
        idle(4);
        check("postrst_frame", frame_pix, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
